// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch requester: FSM states,
// bus response codes, the NOP substituted on bus errors and the boot PC.
package ifu_fetch_pkg;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

  localparam logic [1:0]  RESP_OKAY    = 2'b00;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  // A 32-bit instruction has both low bits set; anything else is a 16-bit compressed one.
  function automatic logic is_full_width(input logic [1:0] low_bits);
    return low_bits == 2'b11;
  endfunction

endpackage

// File: rtl/ifu_pc_next.sv
// Next-PC select: redirect target, squashed-fetch target, sequential
// increment by instruction length, or hold. Wraps modulo 2^XLEN.
module ifu_pc_next
  import ifu_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            sel_redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            sel_kill,
  input  logic [XLEN-1:0] kill_pc,
  input  logic            sel_incr,
  input  logic [1:0]      inst_low,
  output logic [XLEN-1:0] pc_next
);

  // A live redirect beats a stored squash target, which beats the sequential step.
  always_comb begin
    pc_next = pc;
    if (sel_redirect) begin
      pc_next = redirect_pc;
    end else if (sel_kill) begin
      pc_next = kill_pc;
    end else if (sel_incr) begin
      pc_next = pc + (is_full_width(inst_low) ? XLEN'(4) : XLEN'(2));
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch requester: owns the PC, issues one single-beat read at a
// time, presents each returned word with its PC, and squashes beats that were
// already requested when a redirect arrived.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            ds_ready_i,
  output logic            ar_valid_o,
  input  logic            ar_ready_i,
  output logic [XLEN-1:0] ar_addr_o,
  input  logic            r_valid_i,
  output logic            r_ready_o,
  input  logic [31:0]     r_data_i,
  input  logic [1:0]      r_resp_i,
  output logic [XLEN-1:0] pc_addr_o,
  output logic [31:0]     icache_inst_o,
  output logic            if_rdata_valid_o,
  output logic            fetch_err_o
);

  if_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_next;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] kill_pc_q, kill_pc_d;
  logic            capture;
  logic            sel_redirect, sel_kill, sel_incr;

  ifu_pc_next #(
    .XLEN(XLEN)
  ) u_pc_next (
    .pc          (pc_q),
    .sel_redirect(sel_redirect),
    .redirect_pc (redirect_pc_i),
    .sel_kill    (sel_kill),
    .kill_pc     (kill_pc_q),
    .sel_incr    (sel_incr),
    .inst_low    (icache_inst_o[1:0]),
    .pc_next     (pc_next)
  );

  // The request is gated by reset so nothing is asserted until the cycle reset is released.
  assign ar_valid_o       = rst && (state_q == IF_REQ);
  assign ar_addr_o        = pc_q;
  assign r_ready_o        = (state_q == IF_WAIT);
  assign if_rdata_valid_o = (state_q == IF_HOLD);

  // Next-state logic; a request already on the bus is never withdrawn, so redirects
  // during REQ/WAIT only arm the squash and the beat is discarded when it returns.
  always_comb begin
    state_d      = state_q;
    kill_d       = kill_q;
    kill_pc_d    = kill_pc_q;
    capture      = 1'b0;
    sel_redirect = 1'b0;
    sel_kill     = 1'b0;
    sel_incr     = 1'b0;
    unique case (state_q)
      IF_REQ: begin
        if (redirect_valid_i) begin
          kill_d    = 1'b1;
          kill_pc_d = redirect_pc_i;
        end
        if (ar_ready_i) begin
          state_d = IF_WAIT;
        end
      end
      IF_WAIT: begin
        if (r_valid_i) begin
          if (kill_q || redirect_valid_i) begin
            sel_redirect = redirect_valid_i;
            sel_kill     = kill_q;
            kill_d       = 1'b0;
            state_d      = IF_REQ;
          end else begin
            capture = 1'b1;
            state_d = IF_HOLD;
          end
        end else if (redirect_valid_i) begin
          kill_d    = 1'b1;
          kill_pc_d = redirect_pc_i;
        end
      end
      IF_HOLD: begin
        if (redirect_valid_i) begin
          sel_redirect = 1'b1;
          state_d      = IF_REQ;
        end else if (ds_ready_i) begin
          sel_incr = 1'b1;
          state_d  = IF_REQ;
        end
      end
      default: begin
        state_d = IF_REQ;
      end
    endcase
  end

  // FSM, PC and squash bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IF_REQ;
      pc_q      <= RESET_PC;
      kill_q    <= 1'b0;
      kill_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_next;
      kill_q    <= kill_d;
      kill_pc_q <= kill_pc_d;
    end
  end

  // Presented instruction registers; a bus error is replaced by a NOP and flagged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_addr_o     <= RESET_PC;
      icache_inst_o <= '0;
      fetch_err_o   <= 1'b0;
    end else if (capture) begin
      pc_addr_o     <= pc_q;
      icache_inst_o <= (r_resp_i != RESP_OKAY) ? NOP_INST : r_data_i;
      fetch_err_o   <= (r_resp_i != RESP_OKAY);
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: a table of single fetches, directed
// redirect/stall/wrap/reset sequences, then randomized traffic compared
// against a transaction-level reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        ds_ready_i;
  logic        ar_valid_o;
  logic        ar_ready_i;
  logic [31:0] ar_addr_o;
  logic        r_valid_i;
  logic        r_ready_o;
  logic [31:0] r_data_i;
  logic [1:0]  r_resp_i;
  logic [31:0] pc_addr_o;
  logic [31:0] icache_inst_o;
  logic        if_rdata_valid_o;
  logic        fetch_err_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vecs[5];

  ifu_fetch #(
    .XLEN    (32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .ds_ready_i      (ds_ready_i),
    .ar_valid_o      (ar_valid_o),
    .ar_ready_i      (ar_ready_i),
    .ar_addr_o       (ar_addr_o),
    .r_valid_i       (r_valid_i),
    .r_ready_o       (r_ready_o),
    .r_data_i        (r_data_i),
    .r_resp_i        (r_resp_i),
    .pc_addr_o       (pc_addr_o),
    .icache_inst_o   (icache_inst_o),
    .if_rdata_valid_o(if_rdata_valid_o),
    .fetch_err_o     (fetch_err_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic arr, input logic rv, input logic [31:0] rd,
                               input logic [1:0] rr, input logic dsr, input logic rdv,
                               input logic [31:0] rpc);
    ar_ready_i       = arr;
    r_valid_i        = rv;
    r_data_i         = rd;
    r_resp_i         = rr;
    ds_ready_i       = dsr;
    redirect_valid_i = rdv;
    redirect_pc_i    = rpc;
    @(posedge clk);
    #1;
  endtask

  // One best-case fetch from a requesting state: AR, beat, present, accept.
  task automatic fetchTxn(input string tag, input logic [31:0] data, input logic [1:0] resp,
                          input logic [31:0] addr, input logic [31:0] inst, input logic err);
    checkOutput({tag, "_ar_valid"}, 32'(ar_valid_o), 32'd1);
    checkOutput({tag, "_ar_addr"}, ar_addr_o, addr);
    applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput({tag, "_r_ready"}, 32'(r_ready_o), 32'd1);
    checkOutput({tag, "_early_valid"}, 32'(if_rdata_valid_o), 32'd0);
    applyStimulus(1'b0, 1'b1, data, resp, 1'b0, 1'b0, 32'h0);
    checkOutput({tag, "_valid"}, 32'(if_rdata_valid_o), 32'd1);
    checkOutput({tag, "_pc"}, pc_addr_o, addr);
    checkOutput({tag, "_inst"}, icache_inst_o, inst);
    checkOutput({tag, "_err"}, 32'(fetch_err_o), 32'(err));
    checkOutput({tag, "_no_ar_in_hold"}, 32'(ar_valid_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b0, 32'h0);
  endtask

  logic [31:0] m_pc, m_ppc, m_inst, m_tgt;
  logic        m_out, m_pres, m_sq, m_err, exp_arv;
  logic        arr, rv, dsr, rdv;
  logic [31:0] rd, rpc, hold_inst;
  logic [1:0]  rr;

  initial begin
    vecs[0] = '{32'h0000_0513, 2'b00, 32'h8000_0000, 32'h0000_0513, 1'b0};
    vecs[1] = '{32'h0000_4501, 2'b00, 32'h8000_0004, 32'h0000_4501, 1'b0};
    vecs[2] = '{32'h0000_8082, 2'b00, 32'h8000_0006, 32'h0000_8082, 1'b0};
    vecs[3] = '{32'hDEAD_BEEF, 2'b10, 32'h8000_0008, 32'h0000_0013, 1'b1};
    vecs[4] = '{32'h0000_0513, 2'b00, 32'h8000_000C, 32'h0000_0513, 1'b0};

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_ar_valid", 32'(ar_valid_o), 32'd0);
    checkOutput("rst_r_ready", 32'(r_ready_o), 32'd0);
    checkOutput("rst_valid", 32'(if_rdata_valid_o), 32'd0);
    checkOutput("rst_err", 32'(fetch_err_o), 32'd0);
    checkOutput("rst_pc_addr", pc_addr_o, RST_PC);
    checkOutput("rst_inst", icache_inst_o, 32'h0);
    rst = 1'b1;
    #1;
    checkOutput("release_ar_valid", 32'(ar_valid_o), 32'd1);
    checkOutput("release_ar_addr", ar_addr_o, RST_PC);

    // Table of single fetches including compressed, 32-bit and bus-error beats.
    for (int i = 0; i < 5; i++) begin
      fetchTxn($sformatf("vec%0d", i), vecs[i].data, vecs[i].resp, vecs[i].addr, vecs[i].inst, vecs[i].err);
    end
    checkOutput("after_table_addr", ar_addr_o, 32'h8000_0010);

    // Redirect while waiting for the beat: beat squashed, target fetched.
    applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h8000_0100);
    checkOutput("wait_redir_valid", 32'(if_rdata_valid_o), 32'd0);
    checkOutput("wait_redir_r_ready", 32'(r_ready_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0513, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("squash_valid", 32'(if_rdata_valid_o), 32'd0);
    checkOutput("squash_next_addr", ar_addr_o, 32'h8000_0100);

    // Redirect on the AR handshake, then another in WAIT: the last one wins.
    applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h8000_0100);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'h8000_0200);
    applyStimulus(1'b0, 1'b1, 32'h0000_0513, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("double_redir_valid", 32'(if_rdata_valid_o), 32'd0);
    checkOutput("double_redir_addr", ar_addr_o, 32'h8000_0200);

    // AR stalled five cycles with a redirect in cycle 2: request held steady.
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall_ar_valid", 32'(ar_valid_o), 32'd1);
      checkOutput("stall_ar_addr", ar_addr_o, 32'h8000_0200);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, (c == 1), 32'h8000_0300);
    end
    checkOutput("stall_ar_addr_final", ar_addr_o, 32'h8000_0200);
    applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0513, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("stall_squash_valid", 32'(if_rdata_valid_o), 32'd0);
    checkOutput("stall_redir_addr", ar_addr_o, 32'h8000_0300);

    // Downstream stalls in HOLD, then redirect together with ds_ready.
    applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0513, 2'b00, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      checkOutput("hold_valid", 32'(if_rdata_valid_o), 32'd1);
      checkOutput("hold_pc", pc_addr_o, 32'h8000_0300);
      checkOutput("hold_inst", icache_inst_o, 32'h0000_0513);
      checkOutput("hold_no_ar", 32'(ar_valid_o), 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 1'b1, 32'h8000_0400);
    checkOutput("redir_ds_valid", 32'(if_rdata_valid_o), 32'd0);
    checkOutput("redir_ds_addr", ar_addr_o, 32'h8000_0400);

    // PC wraps from FFFF_FFFE to 0 after a compressed instruction.
    applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 1'b1, 32'h0000_0513, 2'b00, 1'b0, 1'b0, 32'h0);
    fetchTxn("wrap", 32'h0000_4501, 2'b00, 32'hFFFF_FFFE, 32'h0000_4501, 1'b0);
    checkOutput("wrap_addr", ar_addr_o, 32'h0000_0000);

    // Redirect arriving on the same cycle as the beat squashes it.
    applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0513, 2'b00, 1'b0, 1'b1, 32'h8000_0500);
    checkOutput("beat_redir_valid", 32'(if_rdata_valid_o), 32'd0);
    checkOutput("beat_redir_addr", ar_addr_o, 32'h8000_0500);

    // Reset in the middle of a transaction clears everything.
    applyStimulus(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    checkOutput("midrst_ar_valid", 32'(ar_valid_o), 32'd0);
    checkOutput("midrst_r_ready", 32'(r_ready_o), 32'd0);
    checkOutput("midrst_pc_addr", pc_addr_o, RST_PC);
    rst = 1'b1;
    #1;
    fetchTxn("cmp_boot", 32'h0000_4501, 2'b00, RST_PC, 32'h0000_4501, 1'b0);
    checkOutput("cmp_boot_next", ar_addr_o, 32'h8000_0002);

    // Randomized traffic against a transaction-level model.
    m_pc   = 32'h8000_0002;
    m_ppc  = 32'h0;
    m_inst = 32'h0;
    m_tgt  = 32'h0;
    m_out  = 1'b0;
    m_pres = 1'b0;
    m_sq   = 1'b0;
    m_err  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      exp_arv = !m_out && !m_pres;
      checkOutput("rnd_ar_valid", 32'(ar_valid_o), 32'(exp_arv));
      if (exp_arv) checkOutput("rnd_ar_addr", ar_addr_o, m_pc);
      checkOutput("rnd_r_ready", 32'(r_ready_o), 32'(m_out));
      checkOutput("rnd_valid", 32'(if_rdata_valid_o), 32'(m_pres));
      if (m_pres) begin
        checkOutput("rnd_pc", pc_addr_o, m_ppc);
        checkOutput("rnd_inst", icache_inst_o, m_inst);
        checkOutput("rnd_err", 32'(fetch_err_o), 32'(m_err));
      end

      arr = 1'($urandom_range(0, 1));
      rv  = m_out && ($urandom_range(0, 1) == 1);
      rd  = $urandom;
      rr  = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
      dsr = ($urandom_range(0, 2) != 0);
      rdv = ($urandom_range(0, 7) == 0);
      rpc = $urandom & 32'hFFFF_FFFE;

      if (m_pres) begin
        if (rdv) begin
          m_pc   = rpc;
          m_pres = 1'b0;
        end else if (dsr) begin
          m_pc   = m_ppc + ((m_inst[1:0] == 2'b11) ? 32'd4 : 32'd2);
          m_pres = 1'b0;
        end
      end else if (!m_out) begin
        if (rdv) begin
          m_sq  = 1'b1;
          m_tgt = rpc;
        end
        if (arr) m_out = 1'b1;
      end else if (rv) begin
        m_out = 1'b0;
        if (rdv) begin
          m_pc = rpc;
          m_sq = 1'b0;
        end else if (m_sq) begin
          m_pc = m_tgt;
          m_sq = 1'b0;
        end else begin
          hold_inst = (rr != 2'b00) ? 32'h0000_0013 : rd;
          m_pres    = 1'b1;
          m_ppc     = m_pc;
          m_inst    = hold_inst;
          m_err     = (rr != 2'b00);
        end
      end else if (rdv) begin
        m_sq  = 1'b1;
        m_tgt = rpc;
      end

      applyStimulus(arr, rv, rd, rr, dsr, rdv, rpc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
